// File: rtl/snn_pkg.sv
// Shared types and arithmetic helpers for the SNN core neuron scheduler.
package snn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_INTEGRATE,
    ST_LEAK,
    ST_FIRE,
    ST_SPIKE
  } state_e;

  localparam logic RESET_ABSOLUTE = 1'b0;
  localparam logic RESET_LINEAR   = 1'b1;

  // Signed add of two sign-extended operands, clamped to a w-bit signed range.
  function automatic int sat_add(input int a, input int b, input int w);
    longint sum;
    longint hi;
    longint lo;
    sum = longint'(a) + longint'(b);
    hi  = (longint'(1) <<< (w - 1)) - longint'(1);
    lo  = -(longint'(1) <<< (w - 1));
    if (sum > hi) return int'(hi);
    if (sum < lo) return int'(lo);
    return int'(sum);
  endfunction

endpackage

// File: rtl/neuron_update.sv
// Combinational threshold / reset evaluation applied to the leaked accumulator.
module neuron_update
  import snn_pkg::*;
#(
  parameter int POTENTIAL_WIDTH = 9,
  parameter int THRESHOLD_WIDTH = 9,
  parameter int NUM_RESET_MODES = 2
) (
  input  logic signed [POTENTIAL_WIDTH-1:0] acc_i,
  input  logic signed [THRESHOLD_WIDTH-1:0] pos_thr_i,
  input  logic signed [THRESHOLD_WIDTH-1:0] neg_thr_i,
  input  logic signed [THRESHOLD_WIDTH-1:0] reset_pot_i,
  input  logic                              reset_mode_i,
  output logic                              fire_o,
  output logic signed [POTENTIAL_WIDTH-1:0] new_pot_o
);

  always_comb begin
    fire_o    = 1'b0;
    new_pot_o = acc_i;
    if (int'(acc_i) >= int'(pos_thr_i)) begin
      fire_o = 1'b1;
      if (NUM_RESET_MODES > 1 && reset_mode_i == RESET_LINEAR)
        new_pot_o = POTENTIAL_WIDTH'(sat_add(int'(acc_i), -int'(pos_thr_i), POTENTIAL_WIDTH));
      else
        new_pot_o = POTENTIAL_WIDTH'(int'(reset_pot_i));
    end else if (int'(acc_i) < int'(neg_thr_i)) begin
      new_pot_o = POTENTIAL_WIDTH'(int'(neg_thr_i));
    end
  end

endmodule

// File: rtl/neuron_scheduler.sv
// Per-tick sequencer: walks every neuron and axon, integrates, leaks, fires and writes back.
module neuron_scheduler
  import snn_pkg::*;
#(
  parameter int NUM_AXONS       = 256,
  parameter int NUM_NEURONS     = 256,
  parameter int WEIGHT_WIDTH    = 9,
  parameter int POTENTIAL_WIDTH = 9,
  parameter int LEAK_WIDTH      = 9,
  parameter int THRESHOLD_WIDTH = 9,
  parameter int NUM_WEIGHTS     = 4,
  parameter int NUM_RESET_MODES = 2,
  localparam int TW = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1,
  localparam int AW = (NUM_AXONS > 1) ? $clog2(NUM_AXONS) : 1,
  localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  tick_i,
  input  logic [NUM_AXONS-1:0]                  axon_spikes_i,
  input  logic [NUM_AXONS*TW-1:0]               axon_types_i,
  output logic                                  mem_rd_en_o,
  output logic [NW-1:0]                         mem_addr_o,
  input  logic [NUM_AXONS-1:0]                  syn_row_i,
  input  logic [NUM_WEIGHTS*WEIGHT_WIDTH-1:0]   nrn_weights_i,
  input  logic signed [LEAK_WIDTH-1:0]          nrn_leak_i,
  input  logic signed [THRESHOLD_WIDTH-1:0]     nrn_pos_thr_i,
  input  logic signed [THRESHOLD_WIDTH-1:0]     nrn_neg_thr_i,
  input  logic signed [THRESHOLD_WIDTH-1:0]     nrn_reset_pot_i,
  input  logic                                  nrn_reset_mode_i,
  input  logic signed [POTENTIAL_WIDTH-1:0]     nrn_potential_i,
  output logic                                  pot_we_o,
  output logic signed [POTENTIAL_WIDTH-1:0]     pot_wdata_o,
  output logic [WEIGHT_WIDTH-1:0]               integ_weight_o,
  output logic                                  integ_axon_o,
  output logic                                  integ_syn_o,
  input  logic signed [POTENTIAL_WIDTH-1:0]     integ_potential_i,
  output logic                                  spike_valid_o,
  output logic [NW-1:0]                         spike_neuron_o,
  input  logic                                  spike_ready_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic                                  overrun_o,
  output state_e                                dbg_state_o
);

  state_e                             state_q, state_d;
  logic [NUM_AXONS-1:0]               spikes_q, row_q;
  logic [AW-1:0]                      axon_q;
  logic [NW-1:0]                      nrn_q;
  logic [NUM_WEIGHTS*WEIGHT_WIDTH-1:0] weights_q;
  logic signed [LEAK_WIDTH-1:0]       leak_q;
  logic signed [THRESHOLD_WIDTH-1:0]  pos_thr_q, neg_thr_q, reset_pot_q;
  logic                               mode_q;
  logic signed [POTENTIAL_WIDTH-1:0]  acc_q;
  logic                               overrun_q;
  logic                               advance;
  logic                               fire;
  logic signed [POTENTIAL_WIDTH-1:0]  new_pot;
  logic [TW-1:0]                      cur_type;
  logic                               axon_last, nrn_last;

  assign axon_last   = (axon_q == AW'(NUM_AXONS - 1));
  assign nrn_last    = (nrn_q == NW'(NUM_NEURONS - 1));
  assign cur_type    = axon_types_i[int'(axon_q)*TW +: TW];
  assign busy_o      = (state_q != ST_IDLE);
  assign overrun_o   = overrun_q;
  assign dbg_state_o = state_q;

  neuron_update #(
    .POTENTIAL_WIDTH(POTENTIAL_WIDTH),
    .THRESHOLD_WIDTH(THRESHOLD_WIDTH),
    .NUM_RESET_MODES(NUM_RESET_MODES)
  ) u_update (
    .acc_i       (acc_q),
    .pos_thr_i   (pos_thr_q),
    .neg_thr_i   (neg_thr_q),
    .reset_pot_i (reset_pot_q),
    .reset_mode_i(mode_q),
    .fire_o      (fire),
    .new_pot_o   (new_pot)
  );

  // Spike handshake: spike_valid_o rises in FIRE and, once up, stays up with a
  // stable spike_neuron_o until the cycle spike_ready_i is high; that cycle is
  // the transfer and the sequencer moves on in the same cycle.
  always_comb begin
    state_d        = state_q;
    advance        = 1'b0;
    mem_rd_en_o    = 1'b0;
    mem_addr_o     = '0;
    pot_we_o       = 1'b0;
    pot_wdata_o    = '0;
    integ_weight_o = '0;
    integ_axon_o   = 1'b0;
    integ_syn_o    = 1'b0;
    spike_valid_o  = 1'b0;
    spike_neuron_o = '0;
    done_o         = 1'b0;
    case (state_q)
      ST_IDLE: if (tick_i) state_d = ST_FETCH;
      ST_FETCH: begin
        mem_rd_en_o = 1'b1;
        mem_addr_o  = nrn_q;
        state_d     = ST_LOAD;
      end
      ST_LOAD: state_d = ST_INTEGRATE;
      ST_INTEGRATE: begin
        integ_axon_o   = spikes_q[axon_q];
        integ_syn_o    = row_q[axon_q];
        integ_weight_o = weights_q[int'(cur_type)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        if (axon_last) state_d = ST_LEAK;
      end
      ST_LEAK: state_d = ST_FIRE;
      ST_FIRE: begin
        pot_we_o    = 1'b1;
        pot_wdata_o = new_pot;
        mem_addr_o  = nrn_q;
        if (fire) begin
          spike_valid_o  = 1'b1;
          spike_neuron_o = nrn_q;
        end
        if (fire && !spike_ready_i) state_d = ST_SPIKE;
        else advance = 1'b1;
      end
      ST_SPIKE: begin
        spike_valid_o  = 1'b1;
        spike_neuron_o = nrn_q;
        if (spike_ready_i) advance = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Leaving a neuron costs no extra cycle: choose the next one here.
    if (advance) begin
      if (nrn_last) begin
        state_d = ST_IDLE;
        done_o  = 1'b1;
      end else begin
        state_d = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      spikes_q    <= '0;
      row_q       <= '0;
      axon_q      <= '0;
      nrn_q       <= '0;
      weights_q   <= '0;
      leak_q      <= '0;
      pos_thr_q   <= '0;
      neg_thr_q   <= '0;
      reset_pot_q <= '0;
      mode_q      <= 1'b0;
      acc_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      overrun_q <= tick_i && (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (tick_i) begin
            spikes_q <= axon_spikes_i;
            nrn_q    <= '0;
          end
        end
        ST_LOAD: begin
          row_q       <= syn_row_i;
          weights_q   <= nrn_weights_i;
          leak_q      <= nrn_leak_i;
          pos_thr_q   <= nrn_pos_thr_i;
          neg_thr_q   <= nrn_neg_thr_i;
          reset_pot_q <= nrn_reset_pot_i;
          mode_q      <= nrn_reset_mode_i;
          acc_q       <= nrn_potential_i;
          axon_q      <= '0;
        end
        ST_INTEGRATE: begin
          acc_q  <= POTENTIAL_WIDTH'(sat_add(int'(acc_q), int'(integ_potential_i), POTENTIAL_WIDTH));
          axon_q <= axon_q + AW'(1);
        end
        ST_LEAK: acc_q <= POTENTIAL_WIDTH'(sat_add(int'(acc_q), int'(leak_q), POTENTIAL_WIDTH));
        default: ;
      endcase
      if (advance && !nrn_last) nrn_q <= nrn_q + NW'(1);
    end
  end

endmodule

// File: tb/tb_neuron_scheduler.sv
// Bench for neuron_scheduler with 4 axons and 2 neurons: vector table, corner sequences, random vs model.
module tb_neuron_scheduler;
  import snn_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        tick_i;
  logic [3:0]  axon_spikes_i;
  logic [7:0]  axon_types_i;
  logic        mem_rd_en_o;
  logic [0:0]  mem_addr_o;
  logic [3:0]  syn_row_i;
  logic [35:0] nrn_weights_i;
  logic [8:0]  nrn_leak_i, nrn_pos_thr_i, nrn_neg_thr_i, nrn_reset_pot_i, nrn_potential_i;
  logic        nrn_reset_mode_i;
  logic        pot_we_o;
  logic [8:0]  pot_wdata_o;
  logic [8:0]  integ_weight_o;
  logic        integ_axon_o, integ_syn_o;
  logic [8:0]  integ_potential_i;
  logic        spike_valid_o;
  logic [0:0]  spike_neuron_o;
  logic        spike_ready_i;
  logic        busy_o, done_o, overrun_o;
  state_e      dbg_state;

  neuron_scheduler #(.NUM_AXONS(4), .NUM_NEURONS(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tick_i(tick_i),
    .axon_spikes_i(axon_spikes_i), .axon_types_i(axon_types_i),
    .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o),
    .syn_row_i(syn_row_i), .nrn_weights_i(nrn_weights_i), .nrn_leak_i(nrn_leak_i),
    .nrn_pos_thr_i(nrn_pos_thr_i), .nrn_neg_thr_i(nrn_neg_thr_i),
    .nrn_reset_pot_i(nrn_reset_pot_i), .nrn_reset_mode_i(nrn_reset_mode_i),
    .nrn_potential_i(nrn_potential_i), .pot_we_o(pot_we_o), .pot_wdata_o(pot_wdata_o),
    .integ_weight_o(integ_weight_o), .integ_axon_o(integ_axon_o), .integ_syn_o(integ_syn_o),
    .integ_potential_i(integ_potential_i), .spike_valid_o(spike_valid_o),
    .spike_neuron_o(spike_neuron_o), .spike_ready_i(spike_ready_i),
    .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o), .dbg_state_o(dbg_state)
  );

  always #5 clk_i = ~clk_i;

  // Neuron memory with one-cycle read latency, and the external integrator.
  logic [3:0] m_row[2];
  int         m_w[2][4];
  int         m_leak[2], m_pos[2], m_neg[2], m_rpot[2], m_pot[2];
  logic       m_mode[2];
  logic [0:0] rd_idx = 1'b0;

  always @(posedge clk_i) if (mem_rd_en_o) rd_idx <= mem_addr_o;

  assign syn_row_i        = m_row[rd_idx];
  assign nrn_weights_i    = {9'(m_w[rd_idx][3]), 9'(m_w[rd_idx][2]), 9'(m_w[rd_idx][1]), 9'(m_w[rd_idx][0])};
  assign nrn_leak_i       = 9'(m_leak[rd_idx]);
  assign nrn_pos_thr_i    = 9'(m_pos[rd_idx]);
  assign nrn_neg_thr_i    = 9'(m_neg[rd_idx]);
  assign nrn_reset_pot_i  = 9'(m_rpot[rd_idx]);
  assign nrn_reset_mode_i = m_mode[rd_idx];
  assign nrn_potential_i  = 9'(m_pot[rd_idx]);
  assign integ_potential_i = (integ_axon_o && integ_syn_o) ? integ_weight_o : 9'd0;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, t0 = 0, done_cyc = 0, fetch1_cyc = -1, hs0_cyc = -1, ovr_cnt = 0, stall_left = 0;
  bit done_seen = 0, prev_hold = 0;
  logic [0:0] prev_idx = 1'b0;
  int wb_addr[$], wb_data[$], sp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive after the rising edge, sample on the falling edge.
  task automatic step(input logic t);
    @(posedge clk_i); #1;
    tick_i = t;
    if (spike_valid_o && stall_left > 0) begin
      spike_ready_i = 1'b0;
      stall_left--;
    end else begin
      spike_ready_i = 1'b1;
    end
    @(negedge clk_i);
    cyc++;
    if (pot_we_o) begin
      wb_addr.push_back(int'(mem_addr_o));
      wb_data.push_back(int'($signed(pot_wdata_o)));
    end
    if (mem_rd_en_o && mem_addr_o == 1'b1) fetch1_cyc = cyc;
    if (spike_valid_o && spike_ready_i) begin
      sp_q.push_back(int'(spike_neuron_o));
      if (spike_neuron_o == 1'b0) hs0_cyc = cyc;
    end
    if (prev_hold) begin
      check("valid_held", int'(spike_valid_o), 1);
      check("index_held", int'(spike_neuron_o), int'(prev_idx));
    end
    prev_hold = spike_valid_o && !spike_ready_i;
    prev_idx  = spike_neuron_o;
    if (done_o) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
    if (overrun_o) ovr_cnt++;
  endtask

  task automatic run_ts(input logic [3:0] spk, input int extra_tick, output int lat);
    wb_addr.delete(); wb_data.delete(); sp_q.delete();
    ovr_cnt = 0; done_seen = 0; fetch1_cyc = -1; hs0_cyc = -1; prev_hold = 0;
    axon_spikes_i = spk;
    step(1'b1);
    t0 = cyc;
    step(1'b0);
    axon_spikes_i = ~spk;  // buffer must already be latched
    for (int k = 0; k < 300 && !done_seen; k++) step(cyc + 1 - t0 == extra_tick);
    check("done_seen", int'(done_seen), 1);
    lat = done_seen ? done_cyc - t0 : -1;
    repeat (3) step(1'b0);
    check("busy_after_done", int'(busy_o), 0);
  endtask

  task automatic check_ts(input int e0, input int e1, input bit f0, input bit f1,
                          input int elat, input int lat, input int eovr);
    int ew[2];
    int es[$];
    ew = '{e0, e1};
    check("wb_count", wb_addr.size(), 2);
    for (int i = 0; i < wb_addr.size() && i < 2; i++) begin
      check("wb_addr", wb_addr[i], i);
      check("wb_data", wb_data[i], ew[i]);
    end
    if (f0) es.push_back(0);
    if (f1) es.push_back(1);
    check("spike_count", sp_q.size(), es.size());
    for (int i = 0; i < sp_q.size() && i < es.size(); i++) check("spike_index", sp_q[i], es[i]);
    check("latency", lat, elat);
    check("overrun_count", ovr_cnt, eovr);
  endtask

  function automatic int clamp9(input int x);
    return (x > 255) ? 255 : (x < -256) ? -256 : x;
  endfunction

  // Reference: accumulate contributions with saturation, leak, then threshold rules.
  function automatic void model(input int n, input logic [3:0] spk, output int np, output bit f);
    int acc;
    acc = m_pot[n];
    for (int a = 0; a < 4; a++)
      if (spk[a] && m_row[n][a]) acc = clamp9(acc + m_w[n][int'(axon_types_i[2*a +: 2])]);
    acc = clamp9(acc + m_leak[n]);
    f = (acc >= m_pos[n]);
    if (f) np = m_mode[n] ? clamp9(acc - m_pos[n]) : m_rpot[n];
    else   np = (acc < m_neg[n]) ? m_neg[n] : acc;
  endfunction

  typedef struct {
    logic [3:0] spk;
    logic [3:0] row;
    int         w[4];
    int         pot0, pot1, leak, pos, neg, rpot;
    bit         mode;
    int         exp0, exp1;
    bit         fire0, fire1;
  } vec_t;

  vec_t vecs[6];

  task automatic load_vec(input vec_t v);
    for (int n = 0; n < 2; n++) begin
      m_row[n] = v.row; m_w[n] = v.w; m_leak[n] = v.leak; m_pos[n] = v.pos;
      m_neg[n] = v.neg; m_rpot[n] = v.rpot; m_mode[n] = v.mode;
    end
    m_pot[0] = v.pot0;
    m_pot[1] = v.pot1;
  endtask

  initial begin
    int lat, s, e0, e1;
    bit f0, f1;
    logic [3:0] spk;

    vecs[0] = '{4'b1101, 4'b1111, '{5, -2, 3, 1}, 0, 0, 0, 100, -100, 0, 1'b0, 9, 9, 1'b0, 1'b0};
    vecs[1] = '{4'b1101, 4'b1111, '{5, -2, 3, 1}, 0, 0, 0, 8, -100, 0, 1'b0, 0, 0, 1'b1, 1'b1};
    vecs[2] = '{4'b1101, 4'b1111, '{5, -2, 3, 1}, 0, 0, 0, 8, -100, 0, 1'b1, 1, 1, 1'b1, 1'b1};
    vecs[3] = '{4'b1111, 4'b1111, '{100, 100, 100, 100}, 250, -5, -5, 255, -100, 0, 1'b0, 250, 250, 1'b0, 1'b0};
    vecs[4] = '{4'b1111, 4'b1111, '{-100, -100, -100, -100}, -250, 0, 0, 100, -50, 0, 1'b0, -50, -50, 1'b0, 1'b0};
    vecs[5] = '{4'b1111, 4'b0101, '{10, 20, 30, 40}, 7, -3, -2, 40, -10, -5, 1'b0, -5, 35, 1'b1, 1'b0};

    rst_i = 1'b1; tick_i = 1'b0; spike_ready_i = 1'b1;
    axon_spikes_i = 4'b0000; axon_types_i = 8'b11_10_01_00;
    load_vec(vecs[0]);
    repeat (2) @(negedge clk_i);
    check("rst_busy", int'(busy_o), 0);
    check("rst_valid", int'(spike_valid_o), 0);
    check("rst_rd_en", int'(mem_rd_en_o), 0);
    check("rst_we", int'(pot_we_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_overrun", int'(overrun_o), 0);
    check("rst_state", int'(dbg_state), int'(ST_IDLE));
    @(posedge clk_i); #1 rst_i = 1'b0;

    // Vector table with ready held high.
    foreach (vecs[i]) begin
      load_vec(vecs[i]);
      stall_left = 0;
      run_ts(vecs[i].spk, -1, lat);
      check_ts(vecs[i].exp0, vecs[i].exp1, vecs[i].fire0, vecs[i].fire1, 16, lat, 0);
    end

    // Backpressure: ready low for 5 cycles on neuron 0's spike.
    load_vec(vecs[1]);
    stall_left = 5;
    run_ts(vecs[1].spk, -1, lat);
    check_ts(0, 0, 1'b1, 1'b1, 21, lat, 0);
    check("fetch1_after_handshake", fetch1_cyc, hs0_cyc + 1);

    // Tick during INTEGRATE, then tick on the done cycle.
    load_vec(vecs[0]);
    stall_left = 0;
    run_ts(vecs[0].spk, 5, lat);
    check_ts(9, 9, 1'b0, 1'b0, 16, lat, 1);
    run_ts(vecs[0].spk, 16, lat);
    check_ts(9, 9, 1'b0, 1'b0, 16, lat, 1);

    // Reset while integrating neuron 1, then a clean restart.
    wb_addr.delete(); wb_data.delete(); sp_q.delete();
    axon_spikes_i = vecs[0].spk;
    step(1'b1);
    t0 = cyc;
    while (cyc - t0 < 12) step(1'b0);
    check("pre_rst_state", int'(dbg_state), int'(ST_INTEGRATE));
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(negedge clk_i);
    check("mid_rst_busy", int'(busy_o), 0);
    check("mid_rst_rd_en", int'(mem_rd_en_o), 0);
    check("mid_rst_we", int'(pot_we_o), 0);
    check("mid_rst_valid", int'(spike_valid_o), 0);
    check("mid_rst_state", int'(dbg_state), int'(ST_IDLE));
    check("mid_rst_wb_count", wb_addr.size(), 1);
    @(posedge clk_i); #1 rst_i = 1'b0;
    run_ts(vecs[0].spk, -1, lat);
    check_ts(9, 9, 1'b0, 1'b0, 16, lat, 0);

    // Random timesteps against the reference model.
    for (int t = 0; t < 25; t++) begin
      for (int n = 0; n < 2; n++) begin
        m_row[n]  = 4'($urandom);
        for (int k = 0; k < 4; k++) m_w[n][k] = int'($urandom_range(511)) - 256;
        m_pot[n]  = int'($urandom_range(511)) - 256;
        m_leak[n] = int'($urandom_range(40)) - 20;
        m_pos[n]  = int'($urandom_range(300)) - 100;
        m_neg[n]  = int'($urandom_range(256)) - 256;
        m_rpot[n] = int'($urandom_range(511)) - 256;
        m_mode[n] = 1'($urandom);
      end
      axon_types_i = 8'($urandom);
      spk = 4'($urandom);
      s = int'($urandom_range(3));
      model(0, spk, e0, f0);
      model(1, spk, e1, f1);
      stall_left = s;
      run_ts(spk, -1, lat);
      check_ts(e0, e1, f0, f1, 16 + ((f0 || f1) ? s : 0), lat, 0);
      stall_left = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
